// File: rtl/dcache_mem_arbiter.sv
// rtl/dcache_mem_arbiter.sv - round-robin arbiter sharing one cache-line memory port between two requesters
module dcache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              c0_enable_i,
    input  logic              c0_write_i,
    input  logic [ADDR_W-1:0] c0_addr_i,
    input  logic [DATA_W-1:0] c0_data_i,
    output logic              c0_ack_o,
    input  logic              c1_enable_i,
    input  logic              c1_write_i,
    input  logic [ADDR_W-1:0] c1_addr_i,
    input  logic [DATA_W-1:0] c1_data_i,
    output logic              c1_ack_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        COOL = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   grant;
    logic   last_grant;
    logic   winner;
    logic   any_req;

    // Fill data goes to both ports; each port qualifies it with its own ack.
    assign rd_data_o = mem_data_i;

    // Winner selection: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        any_req = c0_enable_i | c1_enable_i;
        winner  = 1'b0;
        if (c0_enable_i && c1_enable_i) begin
            winner = ~last_grant;
        end else if (c1_enable_i) begin
            winner = 1'b1;
        end
    end

    // Next-state and ack routing; acks pass straight through from memory while busy.
    always_comb begin
        next_state = state;
        c0_ack_o   = 1'b0;
        c1_ack_o   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    c0_ack_o   = ~grant;
                    c1_ack_o   = grant;
                    next_state = COOL;
                end
            end
            COOL: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory-side registers: latched once at grant so they stay stable for the whole transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else if (state == IDLE && any_req) begin
            grant        <= winner;
            mem_enable_o <= 1'b1;
            mem_write_o  <= winner ? c1_write_i : c0_write_i;
            mem_addr_o   <= winner ? c1_addr_i  : c0_addr_i;
            mem_data_o   <= winner ? c1_data_i  : c0_data_i;
        end else if (state == BUSY && mem_ack_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            last_grant   <= grant;
        end
    end

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// tb/tb_dcache_mem_arbiter.sv - directed self-checking bench for dcache_mem_arbiter
module tb_dcache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              c0_enable_i = 1'b0;
    logic              c0_write_i = 1'b0;
    logic [ADDR_W-1:0] c0_addr_i = '0;
    logic [DATA_W-1:0] c0_data_i = '0;
    logic              c0_ack_o;
    logic              c1_enable_i = 1'b0;
    logic              c1_write_i = 1'b0;
    logic [ADDR_W-1:0] c1_addr_i = '0;
    logic [DATA_W-1:0] c1_data_i = '0;
    logic              c1_ack_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i = 1'b0;
    logic [DATA_W-1:0] mem_data_i = '0;

    int n_checks = 0;
    int n_pass   = 0;

    dcache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c0_enable_i(c0_enable_i), .c0_write_i(c0_write_i), .c0_addr_i(c0_addr_i),
        .c0_data_i(c0_data_i), .c0_ack_o(c0_ack_o),
        .c1_enable_i(c1_enable_i), .c1_write_i(c1_write_i), .c1_addr_i(c1_addr_i),
        .c1_data_i(c1_data_i), .c1_ack_o(c1_ack_o),
        .rd_data_o(rd_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic reset_dut();
        @(negedge clk_i);
        rst_i = 1'b0;
        c0_enable_i = 1'b0; c1_enable_i = 1'b0; mem_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Bounded wait for mem_enable_o; returns sampled at negedge+1.
    task automatic wait_grant(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i); #1;
            if (mem_enable_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL %s: grant timeout, mem_enable_o=%b required 1", name, mem_enable_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk_i); #1;
        n_checks++;
        if ({mem_enable_o, mem_write_o, c0_ack_o, c1_ack_o} !== 4'b0 || mem_addr_o !== '0 || mem_data_o !== '0)
            $display("FAIL reset_outputs: en=%b wr=%b a0=%b a1=%b addr=%h required all 0",
                     mem_enable_o, mem_write_o, c0_ack_o, c1_ack_o, mem_addr_o);
        else n_pass++;
    endtask

    task automatic test_port0_fill();
        bit early = 1'b0;
        @(negedge clk_i);
        c0_addr_i = 32'h0000_0400; c0_write_i = 1'b0; c0_enable_i = 1'b1;
        wait_grant("t1_grant");
        n_checks++;
        if (mem_addr_o !== 32'h400 || mem_write_o !== 1'b0)
            $display("FAIL t1_req: addr=%h wr=%b required 400/0", mem_addr_o, mem_write_o);
        else n_pass++;
        repeat (9) begin
            @(negedge clk_i); #1;
            if (c0_ack_o !== 1'b0 || c1_ack_o !== 1'b0 || mem_enable_o !== 1'b1) early = 1'b1;
        end
        n_checks++;
        if (early) $display("FAIL t1_wait: ack or enable changed before memory ack, early=%b required 0", early);
        else n_pass++;
        @(negedge clk_i);
        mem_ack_i = 1'b1; mem_data_i = {8{32'h1234_5678}}; #1;
        n_checks++;
        if (c0_ack_o !== 1'b1 || c1_ack_o !== 1'b0 || rd_data_o !== {8{32'h1234_5678}})
            $display("FAIL t1_ack: a0=%b a1=%b required 1/0", c0_ack_o, c1_ack_o);
        else n_pass++;
        @(negedge clk_i);
        mem_ack_i = 1'b0; c0_enable_i = 1'b0; #1;
        n_checks++;
        if (c0_ack_o !== 1'b0 || mem_enable_o !== 1'b0)
            $display("FAIL t1_cool: a0=%b en=%b required 0/0", c0_ack_o, mem_enable_o);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_port;
        reset_dut();
        c0_addr_i = 32'h1000; c0_write_i = 1'b0;
        c1_addr_i = 32'h2000; c1_write_i = 1'b0;
        c0_enable_i = 1'b1; c1_enable_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_port = t[0];
            exp_addr = exp_port ? 32'h2000 : 32'h1000;
            wait_grant("t2_grant");
            n_checks++;
            if (mem_addr_o !== exp_addr)
                $display("FAIL t2_order%0d: addr=%h required %h", t, mem_addr_o, exp_addr);
            else n_pass++;
            @(negedge clk_i); mem_ack_i = 1'b1; #1;
            n_checks++;
            if (c0_ack_o !== ~exp_port || c1_ack_o !== exp_port)
                $display("FAIL t2_ack%0d: a0=%b a1=%b required %b/%b", t, c0_ack_o, c1_ack_o, ~exp_port, exp_port);
            else n_pass++;
            @(negedge clk_i); mem_ack_i = 1'b0;
            if (t == 3) begin
                c0_enable_i = 1'b0; c1_enable_i = 1'b0;
            end
            #1;
            n_checks++;
            if (mem_enable_o !== 1'b0) $display("FAIL t2_gap%0d: en=%b required 0", t, mem_enable_o);
            else n_pass++;
        end
    endtask

    task automatic test_port1_writeback();
        bit moved = 1'b0;
        @(negedge clk_i);
        c1_addr_i = 32'h0000_0BE0; c1_write_i = 1'b1; c1_data_i = {32{8'hA5}}; c1_enable_i = 1'b1;
        wait_grant("t3_grant");
        n_checks++;
        if (mem_write_o !== 1'b1 || mem_addr_o !== 32'hBE0 || mem_data_o !== {32{8'hA5}})
            $display("FAIL t3_req: wr=%b addr=%h data=%h required 1/be0/a5..", mem_write_o, mem_addr_o, mem_data_o);
        else n_pass++;
        c1_data_i = '0; c1_addr_i = 32'hFFFF_FFE0; c1_write_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i); #1;
            if (mem_data_o !== {32{8'hA5}} || mem_addr_o !== 32'hBE0 || mem_write_o !== 1'b1) moved = 1'b1;
        end
        n_checks++;
        if (moved) $display("FAIL t3_hold: mem outputs changed during busy, moved=%b required 0", moved);
        else n_pass++;
        @(negedge clk_i); mem_ack_i = 1'b1; #1;
        n_checks++;
        if (c1_ack_o !== 1'b1 || c0_ack_o !== 1'b0)
            $display("FAIL t3_ack: a0=%b a1=%b required 0/1", c0_ack_o, c1_ack_o);
        else n_pass++;
        @(negedge clk_i); mem_ack_i = 1'b0; c1_enable_i = 1'b0;
    endtask

    task automatic test_spurious_ack();
        @(negedge clk_i); mem_ack_i = 1'b1; #1;
        n_checks++;
        if (c0_ack_o !== 1'b0 || c1_ack_o !== 1'b0)
            $display("FAIL t4_idle_ack: a0=%b a1=%b required 0/0", c0_ack_o, c1_ack_o);
        else n_pass++;
        @(negedge clk_i); mem_ack_i = 1'b0; #1;
        n_checks++;
        if (mem_enable_o !== 1'b0 || mem_addr_o !== 32'hBE0 || mem_write_o !== 1'b0)
            $display("FAIL t4_idle_state: en=%b addr=%h wr=%b required 0/be0/0", mem_enable_o, mem_addr_o, mem_write_o);
        else n_pass++;
        c0_addr_i = 32'h3000; c0_write_i = 1'b0; c0_enable_i = 1'b1;
        wait_grant("t4_grant");
        @(negedge clk_i); mem_ack_i = 1'b1;
        @(negedge clk_i); c0_enable_i = 1'b0; #1;
        n_checks++;
        if (c0_ack_o !== 1'b0 || c1_ack_o !== 1'b0)
            $display("FAIL t4_cool_ack: a0=%b a1=%b required 0/0", c0_ack_o, c1_ack_o);
        else n_pass++;
        @(negedge clk_i); mem_ack_i = 1'b0; #1;
        n_checks++;
        if (mem_enable_o !== 1'b0 || mem_addr_o !== 32'h3000 || c0_ack_o !== 1'b0)
            $display("FAIL t4_cool_state: en=%b addr=%h a0=%b required 0/3000/0", mem_enable_o, mem_addr_o, c0_ack_o);
        else n_pass++;
        @(negedge clk_i); #1;
        n_checks++;
        if (mem_enable_o !== 1'b0) $display("FAIL t4_idle_after: en=%b required 0", mem_enable_o);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        @(negedge clk_i);
        c0_addr_i = 32'h4000; c0_write_i = 1'b1; c0_data_i = {8{32'hDEAD_BEEF}}; c0_enable_i = 1'b1;
        wait_grant("t5_grant");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0; mem_ack_i = 1'b1; #1;
        n_checks++;
        if ({mem_enable_o, mem_write_o, c0_ack_o, c1_ack_o} !== 4'b0 || mem_addr_o !== '0 || mem_data_o !== '0)
            $display("FAIL t5_reset: en=%b wr=%b a0=%b a1=%b addr=%h required all 0",
                     mem_enable_o, mem_write_o, c0_ack_o, c1_ack_o, mem_addr_o);
        else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b1; mem_ack_i = 1'b0; c0_enable_i = 1'b0;
        @(negedge clk_i);
        c0_addr_i = 32'h5000; c0_write_i = 1'b0; c1_addr_i = 32'h6000; c1_write_i = 1'b0;
        c0_enable_i = 1'b1; c1_enable_i = 1'b1;
        wait_grant("t5_tie_grant");
        n_checks++;
        if (mem_addr_o !== 32'h5000) $display("FAIL t5_tie: addr=%h required 5000", mem_addr_o);
        else n_pass++;
        @(negedge clk_i); mem_ack_i = 1'b1;
        @(negedge clk_i); mem_ack_i = 1'b0; c0_enable_i = 1'b0; c1_enable_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        c0_addr_i = 32'h7000; c0_write_i = 1'b0; c0_enable_i = 1'b1;
        wait_grant("t6_grant");
        @(negedge clk_i); mem_ack_i = 1'b1; #1;
        n_checks++;
        if (c0_ack_o !== 1'b1) $display("FAIL t6_ack: a0=%b required 1", c0_ack_o);
        else n_pass++;
        @(negedge clk_i); mem_ack_i = 1'b0; c0_addr_i = 32'h7020; #1;
        n_checks++;
        if (mem_enable_o !== 1'b0) $display("FAIL t6_cool: en=%b required 0", mem_enable_o);
        else n_pass++;
        @(negedge clk_i); #1;
        n_checks++;
        if (mem_enable_o !== 1'b0) $display("FAIL t6_idle: en=%b required 0", mem_enable_o);
        else n_pass++;
        @(negedge clk_i); #1;
        n_checks++;
        if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h7020)
            $display("FAIL t6_regrant: en=%b addr=%h required 1/7020", mem_enable_o, mem_addr_o);
        else n_pass++;
        @(negedge clk_i); mem_ack_i = 1'b1;
        @(negedge clk_i); mem_ack_i = 1'b0; c0_enable_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        test_reset();
        rst_i = 1'b1;
        test_port0_fill();
        test_round_robin();
        test_port1_writeback();
        test_spurious_ack();
        test_reset_midflight();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
